// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl
// Sequencing controller for the microwave countdown timer: keypad entry into an
// M:SS register, load/clear/enable control of the external BCD timer chain,
// magnetron and beep outputs. All outputs are registered.
//
// Optional feature macro: QUICK_START_EN
//   defined   : start with an empty (0:00) entry loads 0:30 and cooks.
//   undefined : start with an empty entry is ignored.
//
// Handshake note: tick, key_valid, start and stop are single-cycle strobes
// sampled on the rising edge; there is no ready/backpressure. key_digit is
// only meaningful in the cycle key_valid is high.
module microwave_timer_ctrl #(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data_min,
  output logic [3:0] timer_data_st,
  output logic [3:0] timer_data_so,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int CW = $clog2(BEEP_TICKS + 1);
  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_TICKS - 1);

  state_t        state_q;
  logic [3:0]    min_q, st_q, so_q;
  logic [3:0]    data_min_q, data_st_q, data_so_q;
  logic          loadn_q, clrn_q, en_q, mag_q, beep_q;
  logic [CW-1:0] beep_cnt_q;

  logic          entry_nz;
  logic          key_ok;
  logic          start_ok;
  logic [3:0]    load_min_d, load_st_d, load_so_d;

  // A digit shift is legal only for a BCD digit and when the digit moving into
  // the seconds-tens position stays within 0-5.
  assign entry_nz = (min_q != 4'd0) || (st_q != 4'd0) || (so_q != 4'd0);
  assign key_ok   = key_valid && (key_digit <= 4'd9) && (so_q <= 4'd5);

`ifdef QUICK_START_EN
  // Empty entry means a 30-second quick cook.
  assign start_ok   = start && door_closed;
  assign load_min_d = entry_nz ? min_q : 4'd0;
  assign load_st_d  = entry_nz ? st_q  : 4'd3;
  assign load_so_d  = entry_nz ? so_q  : 4'd0;
`else
  // Empty entry cannot start a cook.
  assign start_ok   = start && door_closed && entry_nz;
  assign load_min_d = min_q;
  assign load_st_d  = st_q;
  assign load_so_d  = so_q;
`endif

  // Controller FSM with registered outputs; strobe outputs default inactive.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      min_q      <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      data_min_q <= 4'd0;
      data_st_q  <= 4'd0;
      data_so_q  <= 4'd0;
      loadn_q    <= 1'b1;
      clrn_q     <= 1'b1;
      en_q       <= 1'b0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      loadn_q <= 1'b1;
      clrn_q  <= 1'b1;
      en_q    <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (stop) begin
            // Cancel entry only; the chain is left alone.
            state_q <= IDLE;
            min_q   <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
          end else if (start_ok) begin
            state_q    <= LOAD;
            loadn_q    <= 1'b0;
            data_min_q <= load_min_d;
            data_st_q  <= load_st_d;
            data_so_q  <= load_so_d;
          end else if (key_ok) begin
            state_q <= ENTRY;
            min_q   <= st_q;
            st_q    <= so_q;
            so_q    <= key_digit;
          end
        end
        LOAD: begin
          if (stop) begin
            state_q <= IDLE;
            clrn_q  <= 1'b0;
            min_q   <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
          end else if (!door_closed) begin
            state_q <= PAUSE;
          end else begin
            state_q <= COOK;
            mag_q   <= 1'b1;
          end
        end
        COOK: begin
          if (stop || !door_closed) begin
            state_q <= PAUSE;
            mag_q   <= 1'b0;
          end else if (timer_zero) begin
            state_q    <= DONE;
            mag_q      <= 1'b0;
            beep_q     <= 1'b1;
            beep_cnt_q <= '0;
          end else begin
            en_q <= tick;
          end
        end
        PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            clrn_q  <= 1'b0;
            min_q   <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
          end else if (start && door_closed) begin
            state_q <= COOK;
            mag_q   <= 1'b1;
          end
        end
        DONE: begin
          if (stop || (tick && (beep_cnt_q == BEEP_LAST))) begin
            state_q <= IDLE;
            clrn_q  <= 1'b0;
            beep_q  <= 1'b0;
            min_q   <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
          end else if (tick) begin
            beep_cnt_q <= beep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          mag_q   <= 1'b0;
          beep_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_data_min = data_min_q;
  assign timer_data_st  = data_st_q;
  assign timer_data_so  = data_so_q;
  assign timer_loadn    = loadn_q;
  assign timer_clrn     = clrn_q;
  assign timer_en       = en_q;
  assign mag_on         = mag_q;
  assign beep           = beep_q;
  assign dbg_state_o    = state_q;

endmodule
